// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg: shared types and constants for the fetch sequencer slice
package fetch_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        ISSUE,
        BRANCH,
        DONE
    } fseq_state_e;

    localparam logic [8:0] HALT_INST_DEF = 9'h1FF;
    localparam int         PERF_W        = 16;

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory read port and decode/branch handshake
interface fetch_sequencer_if #(
    parameter int A = 4,
    parameter int W = 9
) ();

    logic         imem_req;
    logic [A-1:0] imem_addr;
    logic         imem_rvalid;
    logic [W-1:0] imem_rdata;
    logic         inst_valid;
    logic [W-1:0] inst;
    logic         dec_ready;
    logic         dec_branch;
    logic         br_resolve;
    logic         br_taken;

    modport master (
        output imem_req, imem_addr, inst_valid, inst,
        input  imem_rvalid, imem_rdata, dec_ready, dec_branch, br_resolve, br_taken
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst,
        output imem_rvalid, imem_rdata, dec_ready, dec_branch, br_resolve, br_taken
    );

endinterface

// File: rtl/fseq_perf_cnt.sv
// fseq_perf_cnt: saturating event counter with synchronous clear
module fseq_perf_cnt
    import fetch_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [PERF_W-1:0] cnt_o
);

    logic [PERF_W-1:0] cnt_q;

    // clear wins over increment; the count sticks at all-ones
    always_ff @(posedge clk) begin
        if (reset || clr_i) cnt_q <= '0;
        else if (inc_i && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: control FSM owning the PC register controls, imem reads and
// decode handoff. Define FETCH_SEQ_PERF_EN to add the cyc_cnt/stall_cnt counters.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int           A         = 4,
    parameter int           W         = 9,
    parameter logic [W-1:0] HALT_INST = HALT_INST_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [A-1:0]        start_addr,
    input  logic [A-1:0]        pc,
    output logic                pc_load,
    output logic                pc_hold,
    output logic                pc_branch,
    output logic                pc_take,
    fetch_sequencer_if.master   bus,
    output logic                done
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [PERF_W-1:0]   cyc_cnt,
    output logic [PERF_W-1:0]   stall_cnt
`endif
);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_FETCH  = FETCH;
    localparam logic [2:0] S_WAIT   = WAIT;
    localparam logic [2:0] S_ISSUE  = ISSUE;
    localparam logic [2:0] S_BRANCH = BRANCH;
    localparam logic [2:0] S_DONE   = DONE;

    logic [2:0]   state_q, state_d;
    logic [W-1:0] inst_q, inst_d;
    logic         req, valid;
    logic         unused_start_addr;

    // start_addr goes straight to the PC register; the sequencer only pulses pc_load
    assign unused_start_addr = ^start_addr;

    // next state, instruction latch and all control strobes; reset forces the idle pattern
    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        pc_load   = 1'b0;
        pc_hold   = 1'b1;
        pc_branch = 1'b0;
        pc_take   = 1'b0;
        req       = 1'b0;
        valid     = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                done = (state_q == S_DONE);
                if (start) begin
                    pc_load = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                req     = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    inst_d  = bus.imem_rdata;
                    state_d = (bus.imem_rdata == HALT_INST) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                valid = 1'b1;
                if (bus.dec_ready) begin
                    pc_hold = bus.dec_branch;
                    state_d = bus.dec_branch ? S_BRANCH : S_FETCH;
                end
            end
            S_BRANCH: begin
                if (bus.br_resolve) begin
                    pc_hold   = 1'b0;
                    pc_branch = 1'b1;
                    pc_take   = bus.br_taken;
                    state_d   = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (reset) begin
            pc_load   = 1'b0;
            pc_hold   = 1'b1;
            pc_branch = 1'b0;
            pc_take   = 1'b0;
            req       = 1'b0;
            valid     = 1'b0;
            done      = 1'b0;
        end
    end

    // state and registered instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
        end
    end

    assign bus.imem_req   = req;
    assign bus.imem_addr  = pc;
    assign bus.inst_valid = valid;
    assign bus.inst       = inst_q;

`ifdef FETCH_SEQ_PERF_EN
    logic cyc_inc, stall_inc;

    assign cyc_inc   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign stall_inc = (state_q == S_WAIT) || (state_q == S_BRANCH) ||
                       ((state_q == S_ISSUE) && !bus.dec_ready);

    fseq_perf_cnt u_cyc (
        .clk   (clk),
        .reset (reset),
        .clr_i (pc_load),
        .inc_i (cyc_inc),
        .cnt_o (cyc_cnt)
    );

    fseq_perf_cnt u_stall (
        .clk   (clk),
        .reset (reset),
        .clr_i (pc_load),
        .inc_i (stall_inc),
        .cnt_o (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scoreboard bench with PC-register, memory, decode and branch models
module tb_fetch_sequencer;
    import fetch_seq_pkg::*;

    localparam int A = 4;
    localparam int W = 9;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [A-1:0] start_addr = '0;
    logic [A-1:0] pc;
    logic [A-1:0] tgt = 4'hC;
    logic         pc_load, pc_hold, pc_branch, pc_take, done;
`ifdef FETCH_SEQ_PERF_EN
    logic [PERF_W-1:0] cyc_cnt, stall_cnt;
`endif

    fetch_sequencer_if #(.A(A), .W(W)) bus ();

    fetch_sequencer #(.A(A), .W(W), .HALT_INST(9'h1FF)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .pc         (pc),
        .pc_load    (pc_load),
        .pc_hold    (pc_hold),
        .pc_branch  (pc_branch),
        .pc_take    (pc_take),
        .bus        (bus),
        .done       (done)
`ifdef FETCH_SEQ_PERF_EN
        ,
        .cyc_cnt    (cyc_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int           vectors = 0;
    int           miscompares = 0;
    int           hold_pulses = 0;
    int           lat = 1;
    logic [W-1:0] mem [16];
    logic [A-1:0] ma;
    logic [A-1:0] exp_addr [$];
    logic [W-1:0] exp_inst [$];
    logic [1:0]   exp_ev [$];
    logic         br_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: event with no expectation at %0t", nm, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_sig(input int sel, input int budget, output int n);
        n = 0;
        while (!(sel == 0 ? bus.inst_valid : sel == 1 ? done : pc_branch) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: signal %0d not seen within %0d cycles", sel, budget);
        end
    endtask

    task automatic start_run(input logic [A-1:0] a);
        start = 1'b1;
        start_addr = a;
        #1;
        chk("pc_load", pc_load, 1);
        tick();
        start = 1'b0;
        chk("done_drop", done, 0);
    endtask

    // PC register model
    always @(posedge clk) begin
        if (reset) pc <= '0;
        else if (pc_load) pc <= start_addr;
        else if (!pc_hold) pc <= (pc_branch && pc_take) ? tgt : pc + 1'b1;
    end

    // instruction memory: answers each request after lat cycles
    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!reset && bus.imem_req) begin
                ma = bus.imem_addr;
                @(posedge clk);
                repeat (lat - 1) @(posedge clk);
                #1;
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata = mem[ma];
                @(posedge clk);
                #1;
                bus.imem_rvalid = 1'b0;
                bus.imem_rdata = '0;
            end
        end
    end

    // decode: opcode 3'b101 marks a branch
    initial begin
        bus.dec_branch = 1'b0;
        forever begin
            @(bus.inst);
            bus.dec_branch = (bus.inst[8:6] == 3'b101);
        end
    end

    // branch unit: resolves three cycles after a branch is accepted
    initial begin
        bus.br_resolve = 1'b0;
        bus.br_taken = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && bus.inst_valid && bus.dec_ready && bus.dec_branch) begin
                repeat (3) @(posedge clk);
                #1;
                bus.br_resolve = 1'b1;
                if (br_q.size() == 0) flag("br_unexpected");
                else bus.br_taken = br_q.pop_front();
                @(posedge clk);
                #1;
                bus.br_resolve = 1'b0;
                bus.br_taken = 1'b0;
            end
        end
    end

    // monitor: pops expectations whenever the DUT presents an event
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.imem_req) begin
                    if (exp_addr.size() == 0) flag("req_unexpected");
                    else chk("req_addr", bus.imem_addr, exp_addr.pop_front());
                end
                if (bus.inst_valid) begin
                    if (exp_inst.size() == 0) flag("issue_unexpected");
                    else if (bus.dec_ready) chk("inst_issue", bus.inst, exp_inst.pop_front());
                    else chk("inst_hold", bus.inst, exp_inst[0]);
                end
                if (!pc_hold) begin
                    hold_pulses++;
                    if (exp_ev.size() == 0) flag("adv_unexpected");
                    else chk("adv_ctl", {pc_branch, pc_take}, exp_ev.pop_front());
                end else begin
                    chk("hold_ctl", {pc_branch, pc_take}, 2'b00);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, h0;
        bus.dec_ready = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (3) tick();
        chk("reset_outs", {pc_load, pc_branch, pc_take, bus.imem_req, bus.inst_valid, done, pc_hold}, 7'b0000001);
        chk("reset_inst", bus.inst, 0);
        reset = 1'b0;
        tick();
        chk("idle_outs", {pc_load, pc_branch, pc_take, bus.imem_req, bus.inst_valid, done, pc_hold}, 7'b0000001);

        // basic run from 2, 1-cycle memory, decode always ready
        mem[2] = 9'h011; mem[3] = 9'h022; mem[4] = 9'h1FF;
        exp_addr.push_back(2); exp_addr.push_back(3); exp_addr.push_back(4);
        exp_inst.push_back(9'h011); exp_inst.push_back(9'h022);
        exp_ev.push_back(2'b00); exp_ev.push_back(2'b00);
        lat = 1;
        bus.dec_ready = 1'b1;
        start_run(2);
        for (int k = 0; k < 3; k++) begin
            chk("t1_req", bus.imem_req, 1);
            chk("t1_pc", pc, 2 + k);
            tick();
            chk("t1_wait_req", bus.imem_req, 0);
            tick();
            if (k < 2) begin
                chk("t1_valid", bus.inst_valid, 1);
                tick();
            end
        end
        chk("t1_done", done, 1);
        chk("t1_novalid", bus.inst_valid, 0);
        chk("t1_halt_inst", bus.inst, 9'h1FF);
        repeat (3) tick();
        chk("t1_pc_frozen", pc, 4);
        chk("t1_done_held", done, 1);

        // 4-cycle memory latency and two cycles of decode backpressure
        mem[5] = 9'h033; mem[6] = 9'h1FF;
        exp_addr.push_back(5); exp_addr.push_back(6);
        exp_inst.push_back(9'h033);
        exp_ev.push_back(2'b00);
        lat = 4;
        bus.dec_ready = 1'b0;
        h0 = hold_pulses;
        start_run(5);
        wait_sig(0, 20, n);
        chk("t2_latency", n, 5);
        repeat (2) begin
            chk("t2_hold_inst", bus.inst, 9'h033);
            chk("t2_no_adv", pc_hold, 1);
            tick();
        end
        bus.dec_ready = 1'b1;
        #1;
        chk("t2_adv", pc_hold, 0);
        tick();
        chk("t2_valid_drop", bus.inst_valid, 0);
        wait_sig(1, 20, n);
        chk("t2_pulses", hold_pulses - h0, 1);
        chk("t2_pc", pc, 6);

        // branch taken to 0xC, then not taken; restart from DONE at address 0
        mem[0] = 9'h140; mem[12] = 9'h141; mem[13] = 9'h1FF;
        exp_addr.push_back(0); exp_addr.push_back(12); exp_addr.push_back(13);
        exp_inst.push_back(9'h140); exp_inst.push_back(9'h141);
        exp_ev.push_back(2'b11); exp_ev.push_back(2'b10);
        br_q.push_back(1'b1); br_q.push_back(1'b0);
        lat = 1;
        start_run(0);
        wait_sig(2, 20, n);
        chk("t3_br_lat", n, 5);
        chk("t3_take", pc_take, 1);
        chk("t3_req_in_br", bus.imem_req, 0);
        tick();
        chk("t3_br_pulse", pc_branch, 0);
        chk("t3_pc_tgt", pc, 12);
        chk("t3_refetch", bus.imem_req, 1);
        wait_sig(2, 20, n);
        chk("t3_br_lat2", n, 5);
        chk("t3_not_take", pc_take, 0);
        tick();
        chk("t3_pc_seq", pc, 13);
        wait_sig(1, 20, n);
        chk("t3_done", done, 1);

        // reset during WAIT; the late response lands in IDLE and is dropped
        mem[7] = 9'h055;
        exp_addr.push_back(7);
        lat = 4;
        start_run(7);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("t5_rst_outs", {pc_load, pc_branch, pc_take, bus.imem_req, bus.inst_valid, done, pc_hold}, 7'b0000001);
        tick();
        reset = 1'b0;
        chk("t5_idle_inst", bus.inst, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_novalid", bus.inst_valid, 0);
            chk("t5_inst_clr", bus.inst, 0);
        end

        // ten back-to-back instructions, then halt
        for (int i = 0; i < 10; i++) begin
            mem[i] = 9'(i + 1);
            exp_addr.push_back(4'(i));
            exp_inst.push_back(9'(i + 1));
            exp_ev.push_back(2'b00);
        end
        mem[10] = 9'h1FF;
        exp_addr.push_back(10);
        lat = 1;
        start_run(0);
        repeat (30) tick();
`ifdef FETCH_SEQ_PERF_EN
        chk("t6_cyc_cnt", cyc_cnt, 30);
        chk("t6_stall_cnt", stall_cnt, 10);
`endif
        chk("t6_pc", pc, 10);
        chk("t6_req", bus.imem_req, 1);
        wait_sig(1, 20, n);
        chk("t6_done", done, 1);

        chk("q_addr_empty", exp_addr.size(), 0);
        chk("q_inst_empty", exp_inst.size(), 0);
        chk("q_ev_empty", exp_ev.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
